// File: rtl/truth_table_sweep.sv
// Truth-table sweep harness: walks every N_IN-bit vector, waits a settle time, captures y_in.
// Optional golden compare with first-mismatch capture when TRUTH_TABLE_CHECK_EN is defined.
module truth_table_sweep #(
  parameter int N_IN          = 5,
  parameter int SETTLE_CYCLES = 1
`ifdef TRUTH_TABLE_CHECK_EN
  ,
  parameter logic [2**N_IN-1:0] GOLDEN = 32'hFFFF_111F
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_IN-1:0]      vec_out,
  input  logic                 y_in,
  output logic                 busy,
  output logic                 done,
  output logic                 table_valid,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        ones_cnt
`ifdef TRUTH_TABLE_CHECK_EN
  ,
  output logic                 mismatch,
  output logic [N_IN-1:0]      mismatch_idx
`endif
);

  // state  | meaning
  // IDLE   | waiting for start; last table and vector held
  // SETTLE | vec_out driven, counting settle cycles
  // SAMPLE | capture y_in for vec_out, advance or finish
  // FINISH | one-cycle done pulse, table marked valid on exit

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] LAST_VEC    = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

  state_t        state;
  logic [CW-1:0] settle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      vec_out      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      table_valid  <= 1'b0;
      table_out    <= '0;
      ones_cnt     <= '0;
`ifdef TRUTH_TABLE_CHECK_EN
      mismatch     <= 1'b0;
      mismatch_idx <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // abort wins over start so a held abort cannot launch a sweep
          if (start && !abort) begin
            state       <= SETTLE;
            settle_cnt  <= '0;
            vec_out     <= '0;
            table_out   <= '0;
            ones_cnt    <= '0;
            table_valid <= 1'b0;
            busy        <= 1'b1;
`ifdef TRUTH_TABLE_CHECK_EN
            mismatch     <= 1'b0;
            mismatch_idx <= '0;
`endif
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            table_out[vec_out] <= y_in;
            ones_cnt           <= ones_cnt + {{N_IN{1'b0}}, y_in};
`ifdef TRUTH_TABLE_CHECK_EN
            if (!mismatch && (y_in != GOLDEN[vec_out])) begin
              mismatch     <= 1'b1;
              mismatch_idx <= vec_out;
            end
`endif
            if (vec_out == LAST_VEC) begin
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state      <= SETTLE;
              vec_out    <= vec_out + 1'b1;
              settle_cnt <= '0;
            end
          end
        end
        FINISH: begin
          state       <= IDLE;
          table_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweep.sv
// Bench for truth_table_sweep: two instances (SETTLE_CYCLES 1 and 3), run-level scoreboard.
// Golden-compare checks are compiled in when TRUTH_TABLE_CHECK_EN is defined.
module tb_truth_table_sweep;

  localparam logic [31:0] GOLD = 32'hFFFF_111F;

  typedef struct {
    logic [31:0] tbl;
    logic [5:0]  ones;
    logic        mm;
    logic [4:0]  mm_idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_v [2];
  logic        abort_v [2];
  logic        y_v     [2];
  logic [4:0]  vec_o   [2];
  logic        busy_o  [2];
  logic        done_o  [2];
  logic        tv_o    [2];
  logic [31:0] tbl_o   [2];
  logic [5:0]  ones_o  [2];
`ifdef TRUTH_TABLE_CHECK_EN
  logic        mm_o    [2];
  logic [4:0]  mmi_o   [2];
`endif
  int          mode    [2];
  int          pass_cnt = 0;
  int          total    = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  truth_table_sweep #(.N_IN(5), .SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .vec_out(vec_o[0]), .y_in(y_v[0]), .busy(busy_o[0]), .done(done_o[0]),
    .table_valid(tv_o[0]), .table_out(tbl_o[0]), .ones_cnt(ones_o[0])
`ifdef TRUTH_TABLE_CHECK_EN
    , .mismatch(mm_o[0]), .mismatch_idx(mmi_o[0])
`endif
  );

  truth_table_sweep #(.N_IN(5), .SETTLE_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .vec_out(vec_o[1]), .y_in(y_v[1]), .busy(busy_o[1]), .done(done_o[1]),
    .table_valid(tv_o[1]), .table_out(tbl_o[1]), .ones_cnt(ones_o[1])
`ifdef TRUTH_TABLE_CHECK_EN
    , .mismatch(mm_o[1]), .mismatch_idx(mmi_o[1])
`endif
  );

  // 0 reference, 1 tied high, 2 tied low, 3 e input, 4 reference with 8 and 20 forced low
  function automatic logic y_fn(input int m, input logic [4:0] v);
    logic r;
    r = v[4] | (~v[1] & ~v[0]) | (~v[3] & ~v[2]);
    case (m)
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return v[0];
      4:       return (v == 5'd8 || v == 5'd20) ? 1'b0 : r;
      default: return r;
    endcase
  endfunction

  always_comb y_v[0] = y_fn(mode[0], vec_o[0]);
  always_comb y_v[1] = y_fn(mode[1], vec_o[1]);

  task automatic run_sweep(input int inst, input int m, input int sc);
    exp_t        e;
    exp_t        got;
    logic [31:0] gold;
    logic        b;
    int          exp_done, cyc, done_cyc, ndone, run, hold_bad;
    logic [4:0]  prev;
    logic        prev_ok;
    gold = GOLD;
    e.tbl = '0; e.ones = '0; e.mm = 1'b0; e.mm_idx = '0;
    for (int i = 0; i < 32; i++) begin
      b = y_fn(m, 5'(i));
      e.tbl[i] = b;
      e.ones = e.ones + {5'd0, b};
      if (!e.mm && b !== gold[i]) begin e.mm = 1'b1; e.mm_idx = 5'(i); end
    end
    sb.push_back(e);
    mode[inst] = m;
    exp_done = 32 * (sc + 1) + 1;
    start_v[inst] = 1'b1;
    @(posedge clk); #1;
    start_v[inst] = 1'b0;
    cyc = 1; done_cyc = 0; ndone = 0; run = 0; hold_bad = 0; prev = '0; prev_ok = 1'b0;
    while (cyc <= exp_done + 6) begin
      if (done_o[inst]) begin
        ndone++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (busy_o[inst]) begin
        if (prev_ok && vec_o[inst] == prev) run++;
        else begin
          if (prev_ok && run != sc + 1) hold_bad++;
          prev = vec_o[inst]; run = 1; prev_ok = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    got = sb.pop_front();
    total++; if (done_cyc !== exp_done) $display("FAIL done_cycle inst%0d mode%0d got %0d exp %0d", inst, m, done_cyc, exp_done); else pass_cnt++;
    total++; if (ndone !== 1) $display("FAIL done_count inst%0d mode%0d got %0d exp 1", inst, m, ndone); else pass_cnt++;
    total++; if (hold_bad !== 0) $display("FAIL vec_hold inst%0d mode%0d bad_runs %0d exp 0", inst, m, hold_bad); else pass_cnt++;
    total++; if (tbl_o[inst] !== got.tbl) $display("FAIL table inst%0d mode%0d got %h exp %h", inst, m, tbl_o[inst], got.tbl); else pass_cnt++;
    total++; if (ones_o[inst] !== got.ones) $display("FAIL ones inst%0d mode%0d got %0d exp %0d", inst, m, ones_o[inst], got.ones); else pass_cnt++;
    total++; if (tv_o[inst] !== 1'b1) $display("FAIL table_valid inst%0d mode%0d got %b exp 1", inst, m, tv_o[inst]); else pass_cnt++;
    total++; if ({busy_o[inst], vec_o[inst]} !== {1'b0, 5'd31}) $display("FAIL idle_hold inst%0d busy/vec got %b/%0d exp 0/31", inst, busy_o[inst], vec_o[inst]); else pass_cnt++;
`ifdef TRUTH_TABLE_CHECK_EN
    total++; if ({mm_o[inst], mmi_o[inst]} !== {got.mm, (got.mm ? got.mm_idx : 5'd0)}) $display("FAIL mismatch inst%0d mode%0d got %b/%0d exp %b/%0d", inst, m, mm_o[inst], mmi_o[inst], got.mm, got.mm_idx); else pass_cnt++;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < 2; i++) begin
      total++; if ({vec_o[i], tbl_o[i], ones_o[i]} !== '0) $display("FAIL reset_data inst%0d vec %0d tbl %h ones %0d exp 0", i, vec_o[i], tbl_o[i], ones_o[i]); else pass_cnt++;
      total++; if ({busy_o[i], done_o[i], tv_o[i]} !== 3'b000) $display("FAIL reset_flags inst%0d got %b%b%b exp 000", i, busy_o[i], done_o[i], tv_o[i]); else pass_cnt++;
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ref_function();
    run_sweep(0, 0, 1);
    total++; if (tbl_o[0] !== 32'hFFFF_111F) $display("FAIL ref_table_const got %h exp FFFF111F", tbl_o[0]); else pass_cnt++;
    total++; if (ones_o[0] !== 6'd23) $display("FAIL ref_ones_const got %0d exp 23", ones_o[0]); else pass_cnt++;
  endtask

  task automatic test_ties();
    run_sweep(0, 1, 1);
    run_sweep(0, 2, 1);
  endtask

  task automatic test_settle3();
    run_sweep(1, 3, 3);
  endtask

  task automatic test_abort();
    int nd;
    mode[0] = 1;
    start_v[0] = 1'b1; @(posedge clk); #1; start_v[0] = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    total++; if ({busy_o[0], vec_o[0]} !== {1'b1, 5'd5}) $display("FAIL abort_setup busy/vec got %b/%0d exp 1/5", busy_o[0], vec_o[0]); else pass_cnt++;
    abort_v[0] = 1'b1; @(posedge clk); #1; abort_v[0] = 1'b0;
    total++; if ({busy_o[0], done_o[0], tv_o[0]} !== 3'b000) $display("FAIL abort_flags got %b%b%b exp 000", busy_o[0], done_o[0], tv_o[0]); else pass_cnt++;
    total++; if (tbl_o[0] !== 32'h0000_001F) $display("FAIL abort_table got %h exp 0000001F", tbl_o[0]); else pass_cnt++;
    total++; if (ones_o[0] !== 6'd5) $display("FAIL abort_ones got %0d exp 5", ones_o[0]); else pass_cnt++;
    nd = 0;
    repeat (4) begin @(posedge clk); #1; if (done_o[0] || busy_o[0]) nd++; end
    total++; if (nd !== 0) $display("FAIL abort_stays_idle active_cycles %0d exp 0", nd); else pass_cnt++;
    start_v[0] = 1'b1; @(posedge clk); #1; start_v[0] = 1'b0;
    total++; if ({busy_o[0], tbl_o[0], ones_o[0]} !== {1'b1, 32'h0, 6'd0}) $display("FAIL restart_clear busy %b tbl %h ones %0d exp 1/0/0", busy_o[0], tbl_o[0], ones_o[0]); else pass_cnt++;
  endtask

  task automatic test_repulse_reset();
    repeat (19) begin @(posedge clk); #1; end
    start_v[0] = 1'b1; @(posedge clk); #1; start_v[0] = 1'b0;
    total++; if ({busy_o[0], vec_o[0], ones_o[0]} !== {1'b1, 5'd10, 6'd10}) $display("FAIL repulse_ignored busy/vec/ones got %b/%0d/%0d exp 1/10/10", busy_o[0], vec_o[0], ones_o[0]); else pass_cnt++;
    #2; rst_n = 1'b0; #1;
    total++; if ({vec_o[0], tbl_o[0], ones_o[0]} !== '0) $display("FAIL async_reset_data vec %0d tbl %h ones %0d exp 0", vec_o[0], tbl_o[0], ones_o[0]); else pass_cnt++;
    total++; if ({busy_o[0], done_o[0], tv_o[0]} !== 3'b000) $display("FAIL async_reset_flags got %b%b%b exp 000", busy_o[0], done_o[0], tv_o[0]); else pass_cnt++;
`ifdef TRUTH_TABLE_CHECK_EN
    total++; if ({mm_o[1], mmi_o[1]} !== 6'd0) $display("FAIL async_reset_mismatch got %b/%0d exp 0/0", mm_o[1], mmi_o[1]); else pass_cnt++;
`endif
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    total++; if ({busy_o[0], vec_o[0]} !== 6'd0) $display("FAIL post_reset_idle busy/vec got %b/%0d exp 0/0", busy_o[0], vec_o[0]); else pass_cnt++;
  endtask

`ifdef TRUTH_TABLE_CHECK_EN
  task automatic test_check();
    run_sweep(0, 4, 1);
    total++; if ({mm_o[0], mmi_o[0]} !== {1'b1, 5'd8}) $display("FAIL first_mismatch got %b/%0d exp 1/8", mm_o[0], mmi_o[0]); else pass_cnt++;
  endtask
`endif

  initial begin
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    abort_v[0] = 1'b0; abort_v[1] = 1'b0;
    mode[0] = 0; mode[1] = 0;
    test_reset();
    test_ref_function();
    test_ties();
    test_settle3();
    test_abort();
    test_repulse_reset();
`ifdef TRUTH_TABLE_CHECK_EN
    test_check();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/truth_table_sweep.md
Name: truth_table_sweep

Overview:
- Upstream/downstream harness for the 5-input combinational function stage.
- Drives every input combination onto that stage's a..e inputs and waits a programmable settle time.
- Samples the stage's y output for each combination and assembles a truth table plus a ones count.
- Used on the board to exercise the function stage and to display or compare its truth table.

Parameters:
- N_IN, 5, number of function inputs; sweep length is 2**N_IN vectors.
- SETTLE_CYCLES, 1, cycles each vector is held before y is sampled; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  cancel an active sweep.
- vec_out  output  N_IN  current vector; vec_out[N_IN-1] drives a, down to vec_out[0] driving e.
- y_in  input  1  function output for vec_out.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- table_valid  output  1  table_out holds a complete sweep.
- table_out  output  2**N_IN  bit i = y_in sampled with vec_out == i.
- ones_cnt  output  N_IN+1  number of 1 bits captured in the current sweep.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - vec_out, table_out and ones_cnt = 0.
  - busy, done and table_valid = 0.
- State machine:
  - IDLE: start=1 and abort=0 -> SETTLE. On that same edge: vec_out=0, table_out=0, ones_cnt=0, table_valid=0, settle counter=0. abort has priority over start (stay IDLE).
  - SETTLE: settle counter increments each cycle. When counter == SETTLE_CYCLES-1 -> SAMPLE.
  - SAMPLE: table_out[vec_out] <= y_in; ones_cnt <= ones_cnt + y_in.
    - vec_out == 2**N_IN-1 -> FINISH.
    - Otherwise vec_out <= vec_out+1, counter=0 -> SETTLE.
  - FINISH: done=1 and table_valid <= 1 on the transition to IDLE, so table_valid reads 1 from the first IDLE cycle onward. Next state IDLE.
- Signal levels:
  - busy = 1 in SETTLE and SAMPLE; 0 in IDLE and FINISH.
  - done = 1 only in FINISH.
- Timing:
  - Each vector is held for exactly SETTLE_CYCLES+1 cycles; y_in is sampled on the last of them.
  - start edge to FINISH entry = 2**N_IN*(SETTLE_CYCLES+1) cycles.
  - For the defaults, done is high in cycle 65 after the start edge.
- vec_out holds its last value (2**N_IN-1) in IDLE after completion; it is not cleared until the next start.
- start while busy: ignored, no restart.
- abort in SETTLE or SAMPLE: next state IDLE.
  - No SAMPLE write occurs on the abort cycle.
  - done is not pulsed and table_valid stays 0.
  - table_out and ones_cnt keep their partial contents.
- abort in FINISH: ignored; the sweep completes normally.
- Reset mid-sweep: all outputs return immediately to their reset values.
- ones_cnt width N_IN+1 holds the maximum value 2**N_IN without wrap.
- y_in is treated as synchronous to clk (combinational path from vec_out); it is not synchronised.

Optional Feature:
- Macro: TRUTH_TABLE_CHECK_EN.
- When defined:
  - Adds parameter GOLDEN (2**N_IN bits, default 32'hFFFF_111F).
  - Adds output mismatch (1 bit) and mismatch_idx (N_IN bits).
  - In SAMPLE, if y_in != GOLDEN[vec_out] and mismatch=0: mismatch <= 1 and mismatch_idx <= vec_out. Only the first failing index is recorded.
  - Both outputs clear on reset and on an accepted start.
- When not defined: no extra ports or logic; behaviour is otherwise identical.

Test Plan:
- Stimulus: y_in driven by y = a | (~d & ~e) | (~b & ~c) from vec_out, defaults, pulse start. Response: done after 64 sweep cycles; table_out=32'hFFFF_111F; ones_cnt=23; table_valid=1; mismatch=0 with check enabled.
- Stimulus: y_in tied 1, then a second run with y_in tied 0. Response: table_out=32'hFFFF_FFFF with ones_cnt=32; then table_out=0 with ones_cnt=0; done pulses exactly once per run.
- Stimulus: SETTLE_CYCLES=3, y_in=vec_out[0]. Response: each vec_out value is stable for 4 cycles; done at cycle 129; table_out=32'hAAAA_AAAA; ones_cnt=16.
- Stimulus: abort asserted in the SAMPLE cycle for vec_out=5 (y_in=1). Response: IDLE next cycle; no done; table_valid=0; table_out=32'h0000_001F; ones_cnt=5. A subsequent start clears both.
- Stimulus: start re-pulsed mid-sweep, then rst_n=0 asynchronously mid-sweep. Response: the re-pulse is ignored; on reset all outputs go to 0 without waiting for a clk edge; the block stays IDLE until the next start.
- Stimulus (TRUTH_TABLE_CHECK_EN): reference function with index 8 forced to 0. Response: mismatch=1, mismatch_idx=8; remains latched after an injected second error at index 20.
